// File: rtl/parking_entry_frontend_pkg.sv
// Shared types and widths for the parking entry front end.
// Holds the entry FSM encoding, the digit and count widths, and a counter-width helper.
package parking_entry_frontend_pkg;

  localparam int PWD_W       = 2;
  localparam int DIGIT_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIGIT1 = 2'd1,
    ST_DIGIT2 = 2'd2,
    ST_HOLD   = 2'd3
  } entry_state_t;

  // Bits needed for a counter that runs from 0 to n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/parking_entry_frontend_if.sv
// Keypad input and password handshake between the entry front end and its neighbours.
// The slave modport is the front end; the master modport is the keypad/gate side.
interface parking_entry_frontend_if;
  import parking_entry_frontend_pkg::*;

  logic [PWD_W-1:0]       key_digit;
  logic                   key_strobe;
  logic                   key_clear;
  logic                   pwd_ready;
  logic [PWD_W-1:0]       password_1;
  logic [PWD_W-1:0]       password_2;
  logic                   pwd_valid;
  logic                   entry_timeout;
  logic [DIGIT_CNT_W-1:0] digit_count;

  modport master (
    output key_digit, key_strobe, key_clear, pwd_ready,
    input  password_1, password_2, pwd_valid, entry_timeout, digit_count
  );

  modport slave (
    input  key_digit, key_strobe, key_clear, pwd_ready,
    output password_1, password_2, pwd_valid, entry_timeout, digit_count
  );

endinterface

// File: rtl/parking_entry_frontend_debounce.sv
// Sensor debouncer: optional 2-FF synchroniser (PARKING_SENSOR_SYNC_EN), stability counter,
// debounced level and a registered one-cycle pulse the cycle after the level first reads 1.
module parking_entry_frontend_debounce
  import parking_entry_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic sampled;

`ifdef PARKING_SENSOR_SYNC_EN
  logic sync_1, sync_2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  assign sampled = sync_2;
`else
  assign sampled = raw;
`endif

  logic [CW-1:0] cnt;
  logic          level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
      if (sampled == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= sampled;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_entry_frontend.sv
// Entry front end for the parking gate: debounced sensors plus two-digit keypad capture with
// an inter-digit timeout and a valid/ready hold. PARKING_SENSOR_SYNC_EN adds input synchronisers.
module parking_entry_frontend
  import parking_entry_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sensor_entrance_raw,
  input  logic                     sensor_exit_raw,
  parking_entry_frontend_if.slave  key_if,
  output logic                     sensor_entrance,
  output logic                     sensor_exit,
  output logic                     entrance_rise
);

  localparam int            TW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic exit_rise_unused;

  parking_entry_frontend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_entrance (
    .clk(clk), .reset(reset), .raw(sensor_entrance_raw),
    .level(sensor_entrance), .rise(entrance_rise)
  );

  parking_entry_frontend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_exit (
    .clk(clk), .reset(reset), .raw(sensor_exit_raw),
    .level(sensor_exit), .rise(exit_rise_unused)
  );

  entry_state_t           state, state_next;
  logic [TW-1:0]          timer;
  logic                   timer_done;
  logic [PWD_W-1:0]       password_1, password_2;
  logic [DIGIT_CNT_W-1:0] digit_count;
  logic                   pwd_valid, entry_timeout;
  logic                   clear_entry, load_1, load_2, timer_run, timeout_hit;

  assign timer_done = (timer >= TMR_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Priority inside digit entry: clear, then strobe, then timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (entrance_rise) state_next = ST_DIGIT1;
      ST_DIGIT1: begin
        if (key_if.key_clear)       state_next = ST_DIGIT1;
        else if (key_if.key_strobe) state_next = ST_DIGIT2;
        else if (timer_done)        state_next = ST_IDLE;
      end
      ST_DIGIT2: begin
        if (key_if.key_clear)       state_next = ST_DIGIT1;
        else if (key_if.key_strobe) state_next = ST_HOLD;
        else if (timer_done)        state_next = ST_IDLE;
      end
      ST_HOLD:   if (pwd_valid && key_if.pwd_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    clear_entry = 1'b0;
    load_1      = 1'b0;
    load_2      = 1'b0;
    timer_run   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: clear_entry = entrance_rise;
      ST_DIGIT1, ST_DIGIT2: begin
        timer_run = 1'b1;
        if (key_if.key_clear) begin
          clear_entry = 1'b1;
        end else if (key_if.key_strobe) begin
          load_1 = (state == ST_DIGIT1);
          load_2 = (state == ST_DIGIT2);
        end else if (timer_done) begin
          clear_entry = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      password_1    <= '0;
      password_2    <= '0;
      digit_count   <= '0;
      pwd_valid     <= 1'b0;
      entry_timeout <= 1'b0;
      timer         <= '0;
    end else begin
      pwd_valid     <= (state_next == ST_HOLD);
      entry_timeout <= timeout_hit;
      if (clear_entry) begin
        password_1  <= '0;
        password_2  <= '0;
        digit_count <= '0;
      end else if (load_1) begin
        password_1  <= key_if.key_digit;
        digit_count <= DIGIT_CNT_W'(1);
      end else if (load_2) begin
        password_2  <= key_if.key_digit;
        digit_count <= DIGIT_CNT_W'(2);
      end
      if (!timer_run || clear_entry || load_1 || load_2) timer <= '0;
      else if (!timer_done)                               timer <= timer + 1'b1;
    end
  end

  assign key_if.password_1    = password_1;
  assign key_if.password_2    = password_2;
  assign key_if.digit_count   = digit_count;
  assign key_if.pwd_valid     = pwd_valid;
  assign key_if.entry_timeout = entry_timeout;

endmodule

// File: tb/tb_parking_entry_frontend.sv
// Testbench for parking_entry_frontend: directed scenarios plus randomized traffic compared
// cycle by cycle against a behavioural model of the debounce, digit entry and timeout rules.
module tb_parking_entry_frontend;
  import parking_entry_frontend_pkg::*;

  localparam int D = 4;
  localparam int T = 16;
`ifdef PARKING_SENSOR_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = SYNC_LAT + D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw_e = 1'b0;
  logic raw_x = 1'b0;
  logic sensor_entrance, sensor_exit, entrance_rise;

  parking_entry_frontend_if bus();

  parking_entry_frontend #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .sensor_entrance_raw(raw_e), .sensor_exit_raw(raw_x),
    .key_if(bus),
    .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit), .entrance_rise(entrance_rise)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: raw sample history, last-D-sample windows, and an entry "mode"
  // (0 waiting for a car, 1 collecting digits, 2 holding the pair for the gate).
  logic [15:0] m_hist_e, m_hist_x, m_win_e, m_win_x;
  logic        m_lvl_e, m_lvl_x, m_lvl_e_d, m_rise;
  int          m_mode, m_digits, m_quiet;
  logic [1:0]  m_p1, m_p2;
  logic        m_valid, m_timeout;

  function automatic logic deb_flip(input logic [15:0] win, input logic lvl);
    logic [15:0] mask;
    mask = (16'd1 << D) - 16'd1;
    return lvl ? ((win & mask) == 16'd0) : ((win & mask) == mask);
  endfunction

  task automatic model_reset();
    m_hist_e = '0; m_hist_x = '0; m_win_e = '0; m_win_x = '0;
    m_lvl_e = 0; m_lvl_x = 0; m_lvl_e_d = 0; m_rise = 0;
    m_mode = 0; m_digits = 0; m_quiet = 0; m_p1 = 0; m_p2 = 0;
    m_valid = 0; m_timeout = 0;
  endtask

  task automatic model_step(input logic re, input logic rx, input logic st, input logic cl,
                            input logic rd, input logic [1:0] dg);
    logic n_lvl_e, n_lvl_x, n_rise;
    m_hist_e = {m_hist_e[14:0], re};
    m_hist_x = {m_hist_x[14:0], rx};
    m_win_e  = {m_win_e[14:0], m_hist_e[SYNC_LAT]};
    m_win_x  = {m_win_x[14:0], m_hist_x[SYNC_LAT]};
    n_lvl_e  = deb_flip(m_win_e, m_lvl_e) ? ~m_lvl_e : m_lvl_e;
    n_lvl_x  = deb_flip(m_win_x, m_lvl_x) ? ~m_lvl_x : m_lvl_x;
    n_rise   = m_lvl_e & ~m_lvl_e_d;
    m_timeout = 0;
    case (m_mode)
      0: if (m_rise) begin
        m_mode = 1; m_digits = 0; m_p1 = 0; m_p2 = 0; m_quiet = 0;
      end
      1: begin
        if (cl) begin
          m_digits = 0; m_p1 = 0; m_p2 = 0; m_quiet = 0;
        end else if (st) begin
          if (m_digits == 0) begin m_p1 = dg; m_digits = 1; end
          else begin m_p2 = dg; m_digits = 2; m_mode = 2; end
          m_quiet = 0;
        end else if (m_quiet == T - 1) begin
          m_timeout = 1; m_p1 = 0; m_p2 = 0; m_digits = 0; m_mode = 0; m_quiet = 0;
        end else begin
          m_quiet++;
        end
      end
      default: if (rd) m_mode = 0;
    endcase
    m_valid   = (m_mode == 2);
    m_lvl_e_d = m_lvl_e;
    m_lvl_e   = n_lvl_e;
    m_lvl_x   = n_lvl_x;
    m_rise    = n_rise;
  endtask

  task automatic tick();
    logic re, rx, st, cl, rd;
    logic [1:0] dg;
    @(posedge clk);
    re = raw_e; rx = raw_x; st = bus.key_strobe; cl = bus.key_clear;
    rd = bus.pwd_ready; dg = bus.key_digit;
    if (reset) model_reset();
    else model_step(re, rx, st, cl, rd, dg);
    #1;
  endtask

  task automatic apply_reset();
    raw_e = 0; raw_x = 0;
    bus.key_digit = 0; bus.key_strobe = 0; bus.key_clear = 0; bus.pwd_ready = 0;
    reset = 1;
    model_reset();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic enter();
    int n;
    n = 0;
    raw_e = 1;
    while (!m_rise && n < 4 * LAT) begin
      tick();
      n++;
    end
    checks++;
    if (!m_rise) begin
      errors++;
      $display("FAIL enter_wait: no entrance rise after %0d cycles, required within %0d", n, 4 * LAT);
    end else if (entrance_rise !== 1'b1) begin
      errors++;
      $display("FAIL enter_rise: entrance_rise=%b required 1", entrance_rise);
    end
    raw_e = 0;
    tick();
  endtask

  task automatic press(input logic [1:0] d);
    bus.key_digit = d;
    bus.key_strobe = 1;
    tick();
    bus.key_strobe = 0;
  endtask

  task automatic test_reset();
    raw_e = 1;
    bus.key_digit = 0; bus.key_strobe = 0; bus.key_clear = 0; bus.pwd_ready = 0;
    model_reset();
    #1;
    checks++;
    if ({sensor_entrance, sensor_exit, entrance_rise, bus.password_1, bus.password_2,
         bus.pwd_valid, bus.entry_timeout, bus.digit_count} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (sensor_entrance !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_sensor: sensor_entrance=%b required 0", sensor_entrance);
    end
    raw_e = 0;
    reset = 0;
  endtask

  task automatic test_glitch();
    int rises;
    apply_reset();
    raw_e = 1;
    repeat (3) tick();
    raw_e = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (sensor_entrance !== 1'b0) begin
        errors++;
        $display("FAIL glitch_ignored: cycle %0d sensor_entrance=%b required 0", i, sensor_entrance);
      end
    end
    rises = 0;
    raw_e = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (sensor_entrance !== (k >= LAT)) begin
        errors++;
        $display("FAIL debounce_latency: cycle %0d sensor_entrance=%b required %b", k, sensor_entrance, (k >= LAT));
      end
      checks++;
      if (entrance_rise !== (k == LAT + 1)) begin
        errors++;
        $display("FAIL rise_timing: cycle %0d entrance_rise=%b required %b", k, entrance_rise, (k == LAT + 1));
      end
      if (entrance_rise === 1'b1) rises++;
    end
    raw_e = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (entrance_rise === 1'b1) rises++;
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL rise_count: saw %0d entrance_rise pulses, required 1", rises);
    end
  endtask

  task automatic test_normal();
    int drops;
    apply_reset();
    enter();
    press(2'd1);
    checks++;
    if ({bus.password_1, bus.digit_count, bus.pwd_valid} !== {2'd1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL normal_digit1: p1=%0d cnt=%0d valid=%b required 1/1/0", bus.password_1, bus.digit_count, bus.pwd_valid);
    end
    press(2'd2);
    checks++;
    if ({bus.password_1, bus.password_2, bus.digit_count, bus.pwd_valid} !== {2'd1, 2'd2, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL normal_digit2: p1=%0d p2=%0d cnt=%0d valid=%b required 1/2/2/1", bus.password_1, bus.password_2, bus.digit_count, bus.pwd_valid);
    end
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.pwd_valid !== 1'b1 || bus.password_1 !== 2'd1 || bus.password_2 !== 2'd2) drops++;
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL normal_hold: %0d cycles lost valid or passwords, required 0", drops);
    end
    bus.pwd_ready = 1;
    tick();
    bus.pwd_ready = 0;
    checks++;
    if ({bus.pwd_valid, bus.password_1, bus.password_2} !== {1'b0, 2'd1, 2'd2}) begin
      errors++;
      $display("FAIL normal_release: valid=%b p1=%0d p2=%0d required 0/1/2", bus.pwd_valid, bus.password_1, bus.password_2);
    end
  endtask

  task automatic test_timeout();
    int early;
    apply_reset();
    enter();
    press(2'd3);
    checks++;
    if (bus.password_1 !== 2'd3) begin
      errors++;
      $display("FAIL timeout_digit: p1=%0d required 3", bus.password_1);
    end
    early = 0;
    for (int i = 0; i < T - 1; i++) begin
      tick();
      if (bus.entry_timeout !== 1'b0 || bus.password_1 !== 2'd3) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: %0d cycles changed before the limit, required 0", early);
    end
    tick();
    checks++;
    if ({bus.entry_timeout, bus.password_1, bus.digit_count, bus.pwd_valid} !== {1'b1, 2'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_fire: to=%b p1=%0d cnt=%0d valid=%b required 1/0/0/0", bus.entry_timeout, bus.password_1, bus.digit_count, bus.pwd_valid);
    end
    tick();
    checks++;
    if ({bus.entry_timeout, bus.pwd_valid} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_pulse: to=%b valid=%b required 0/0", bus.entry_timeout, bus.pwd_valid);
    end
  endtask

  task automatic test_clear_priority();
    apply_reset();
    enter();
    press(2'd1);
    bus.key_clear = 1;
    bus.key_digit = 2'd2;
    bus.key_strobe = 1;
    tick();
    bus.key_clear = 0;
    bus.key_strobe = 0;
    checks++;
    if ({bus.digit_count, bus.password_1, bus.password_2} !== 6'd0) begin
      errors++;
      $display("FAIL clear_priority: cnt=%0d p1=%0d p2=%0d required 0/0/0", bus.digit_count, bus.password_1, bus.password_2);
    end
    press(2'd3);
    checks++;
    if ({bus.digit_count, bus.password_1, bus.pwd_valid} !== {2'd1, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL clear_stays_digit1: cnt=%0d p1=%0d valid=%b required 1/3/0", bus.digit_count, bus.password_1, bus.pwd_valid);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    enter();
    press(2'd1);
    #2;
    reset = 1;
    #1;
    checks++;
    if ({sensor_entrance, sensor_exit, entrance_rise, bus.password_1, bus.password_2,
         bus.pwd_valid, bus.entry_timeout, bus.digit_count} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: p1=%0d cnt=%0d required all outputs 0 before the edge", bus.password_1, bus.digit_count);
    end
    model_reset();
    #1;
    reset = 0;
    press(2'd2);
    checks++;
    if ({bus.digit_count, bus.password_1, bus.password_2} !== 6'd0) begin
      errors++;
      $display("FAIL reset_idle_strobe: cnt=%0d p1=%0d p2=%0d required 0/0/0", bus.digit_count, bus.password_1, bus.password_2);
    end
    enter();
    press(2'd2);
    checks++;
    if ({bus.digit_count, bus.password_1} !== {2'd1, 2'd2}) begin
      errors++;
      $display("FAIL reset_reentry: cnt=%0d p1=%0d required 1/2", bus.digit_count, bus.password_1);
    end
  endtask

  task automatic test_ignored_strobes();
    apply_reset();
    press(2'd1);
    checks++;
    if ({bus.digit_count, bus.password_1} !== 4'd0) begin
      errors++;
      $display("FAIL idle_strobe: cnt=%0d p1=%0d required 0/0", bus.digit_count, bus.password_1);
    end
    enter();
    press(2'd1);
    press(2'd2);
    press(2'd3);
    checks++;
    if ({bus.password_1, bus.password_2, bus.digit_count, bus.pwd_valid} !== {2'd1, 2'd2, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL hold_strobe: p1=%0d p2=%0d cnt=%0d valid=%b required 1/2/2/1", bus.password_1, bus.password_2, bus.digit_count, bus.pwd_valid);
    end
    bus.key_clear = 1;
    tick();
    bus.key_clear = 0;
    checks++;
    if ({bus.digit_count, bus.pwd_valid} !== {2'd2, 1'b1}) begin
      errors++;
      $display("FAIL hold_clear: cnt=%0d valid=%b required 2/1", bus.digit_count, bus.pwd_valid);
    end
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    apply_reset();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(9) == 0) raw_e = ~raw_e;
      if ($urandom_range(3) == 0) raw_x = ~raw_x;
      bus.key_strobe = (i < 350) ? ($urandom_range(3) == 0) : ($urandom_range(29) == 0);
      bus.key_clear  = ($urandom_range(15) == 0);
      bus.key_digit  = 2'($urandom_range(3));
      bus.pwd_ready  = ($urandom_range(2) == 0);
      tick();
      got = {sensor_entrance, sensor_exit, entrance_rise, bus.password_1, bus.password_2,
             bus.pwd_valid, bus.entry_timeout, bus.digit_count};
      exp = {m_lvl_e, m_lvl_x, m_rise, m_p1, m_p2, m_valid, m_timeout, 2'(m_digits)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle_%0d: got ent/exit/rise/p1/p2/valid/to/cnt=%b required %b", i, got, exp);
      end
    end
    bus.key_strobe = 0;
    bus.key_clear = 0;
    bus.pwd_ready = 0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_normal();
    test_timeout();
    test_clear_priority();
    test_async_reset();
    test_ignored_strobes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
